// File: rtl/data_m_copy_master_if.sv
// data_m bus bundle: one initiator (master) and one responder (slave).
interface data_m_copy_master_if;
  logic        data_m_access;
  logic        data_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;

  modport master (
    output data_m_access,
    output data_m_addr,
    output data_m_data_out,
    output data_m_wr_en,
    output data_m_bytesel,
    input  data_m_ack,
    input  data_m_data_in
  );

  modport slave (
    input  data_m_access,
    input  data_m_addr,
    input  data_m_data_out,
    input  data_m_wr_en,
    input  data_m_bytesel,
    output data_m_ack,
    output data_m_data_in
  );
endinterface

// File: rtl/data_m_copy_master.sv
// Block copy initiator on the data_m bus: read one word, write it, repeat.
// Every bus output is registered; a one-cycle access-low gap follows each
// transaction so the responder's registered duplicate ack falls harmlessly.
module data_m_copy_master #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [19:1]            src_addr,
  input  logic [19:1]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  data_m_copy_master_if.master   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdGap,
    StWr,
    StWrGap,
    StFin
  } state_t;

  state_t                 state;
  logic [19:1]            src_ptr;
  logic [19:1]            dst_ptr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [15:0]            data_latch;

  // Copy sequencer; ack is only looked at in RD/WR, where access is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= StIdle;
      src_ptr             <= '0;
      dst_ptr             <= '0;
      remaining           <= '0;
      data_latch          <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      bus.data_m_access   <= 1'b0;
      bus.data_m_wr_en    <= 1'b0;
      bus.data_m_addr     <= '0;
      bus.data_m_data_out <= '0;
      bus.data_m_bytesel  <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= StFin;
              done  <= 1'b1;
            end else begin
              state              <= StRd;
              busy               <= 1'b1;
              bus.data_m_access  <= 1'b1;
              bus.data_m_wr_en   <= 1'b0;
              bus.data_m_addr    <= src_addr;
              bus.data_m_bytesel <= 2'b11;
            end
          end
        end
        StRd: begin
          if (bus.data_m_ack) begin
            data_latch         <= bus.data_m_data_in;
            src_ptr            <= src_ptr + 19'd1;
            bus.data_m_access  <= 1'b0;
            bus.data_m_bytesel <= 2'b00;
            state              <= StRdGap;
          end
        end
        StRdGap: begin
          state               <= StWr;
          bus.data_m_access   <= 1'b1;
          bus.data_m_wr_en    <= 1'b1;
          bus.data_m_addr     <= dst_ptr;
          bus.data_m_data_out <= data_latch;
          bus.data_m_bytesel  <= 2'b11;
        end
        StWr: begin
          if (bus.data_m_ack) begin
            dst_ptr            <= dst_ptr + 19'd1;
            remaining          <= remaining - COUNT_WIDTH'(1);
            bus.data_m_access  <= 1'b0;
            bus.data_m_wr_en   <= 1'b0;
            bus.data_m_bytesel <= 2'b00;
            state              <= StWrGap;
          end
        end
        StWrGap: begin
          if (remaining == '0) begin
            state <= StFin;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state              <= StRd;
            bus.data_m_access  <= 1'b1;
            bus.data_m_addr    <= src_ptr;
            bus.data_m_bytesel <= 2'b11;
          end
        end
        StFin: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/data_m_copy_master.md
Name: data_m_copy_master

Overview:
- Initiator on the data_m memory bus, i.e. the requesting side of the access/ack handshake that ROM, RAM and peripheral responders implement.
- Copies a block of 16-bit words from a source word address to a destination word address, one read then one write per word.
- Main use is shadowing the BIOS image from ROM into SDRAM at boot. It sits beside the CPU on the bus arbiter's master side.

Parameters:
- COUNT_WIDTH, 16, width of the word_count input and of the internal remaining-words counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a copy. Sampled only in IDLE.
- src_addr  input  19  source word address [19:1]. Captured on accepted start.
- dst_addr  input  19  destination word address [19:1]. Captured on accepted start.
- word_count  input  COUNT_WIDTH  number of words to copy. Captured on accepted start.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle completion pulse.
- data_m_access  output  1  bus request. Held until ack.
- data_m_ack  input  1  responder acknowledge. Registered in responders, so earliest one cycle after access.
- data_m_addr  output  19  word address [19:1].
- data_m_data_in  input  16  read data from the responder. Valid only in the ack cycle; zero otherwise.
- data_m_data_out  output  16  write data.
- data_m_wr_en  output  1  high for write transactions.
- data_m_bytesel  output  2  byte enables. Always 2'b11 during access, 2'b00 otherwise.

Behaviour:
- Reset (asynchronous, any state): state=IDLE.
  - busy, done, data_m_access, data_m_wr_en = 0.
  - data_m_addr = 0, data_m_data_out = 0, data_m_bytesel = 0.
  - Internal counters and the data latch are cleared.
  - A transaction in flight is abandoned. Any later stray ack is ignored.
- All outputs are registered.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - On start=1, latch src/dst/count.
  - If count=0, go to FIN with no bus activity.
  - Otherwise go to RD.
  - start in any other state is ignored.
- RD:
  - data_m_access=1, wr_en=0, addr=src pointer.
  - Hold all bus outputs stable until data_m_ack=1.
  - In the ack cycle, latch data_m_data_in, increment the src pointer, go to RD_GAP.
- RD_GAP:
  - access=0 for exactly one cycle. Then go to WR.
  - This gap is mandatory: responders register ack from access, so a second ack can appear here. It must be ignored.
- WR:
  - access=1, wr_en=1, addr=dst pointer, data_out=latched word.
  - Hold until ack. On ack, increment the dst pointer, decrement remaining, go to WR_GAP.
- WR_GAP:
  - One cycle with access=0 and wr_en=0.
  - If remaining=0, go to FIN. Otherwise go to RD.
- FIN:
  - done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- Ack is honoured only while data_m_access=1. Ack with access=0 never changes state or data.
- Pointer arithmetic is 19-bit modulo. 19'h7FFFF+1 wraps to 0 with no error.
- word_count max is 2^COUNT_WIDTH-1. There is no zero-means-max encoding.
- Throughput with 1-cycle-latency responders: 6 cycles per word (RD 2, RD_GAP 1, WR 2, WR_GAP 1).
- Total time from the start cycle to the done cycle for N>0 words: 1 + 6N cycles.
- Extra ack latency stretches RD/WR only.
- busy covers RD..WR_GAP. It is low in IDLE and FIN.

Test Plan:
- Reset then idle:
  - Stimulus: reset asserted mid-cycle, then deasserted.
  - Response: all outputs 0 immediately. No access for 20 cycles without start.
- Single word, 1-cycle responder model:
  - Stimulus: src=19'h7E000 holding 16'hA55A, dst=19'h00100, count=1.
  - Response: one read at 19'h7E000, then a write of 16'hA55A at 19'h00100 with bytesel=2'b11. done 7 cycles after start. The access-low gap is present between the read and write.
- 4-word block with responder ack delayed 3 cycles:
  - Response: addresses increment by 1 on both sides. Data matches. Access is held stable through the wait. Exactly 8 transactions. done once.
- Stray-ack immunity:
  - Stimulus: responder also pulses ack in every gap cycle.
  - Response: no extra pointer increments. Copied data is unchanged.
- count=0 and wrap:
  - count=0: done the cycle after start, access never rises.
  - src=19'h7FFFF, count=2: reads 19'h7FFFF then 19'h00000.
- Reset mid-copy:
  - Stimulus: reset asserted during WR wait of word 2 of 5.
  - Response: access/wr_en drop asynchronously. No done. A new start of count=1 then completes normally.
